// File: rtl/modred_pkg.sv
// Shared types and defaults for the modular-reduction dispatcher slice.
package modred_pkg;

    localparam int unsigned DEF_WIDTH       = 64;
    localparam int unsigned DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/modred_dispatcher_if.sv
// Link between the dispatcher (master) and the serial modular reducer (slave).
interface modred_dispatcher_if #(
    parameter int unsigned WIDTH = modred_pkg::DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] m_bl;
    logic             valid;
    logic [WIDTH-1:0] result;

    modport master (output start, x, m, m_bl, input valid, result);
    modport slave  (input start, x, m, m_bl, output valid, result);

endinterface

// File: rtl/modred_bitlen.sv
// Combinational ceil(log2(m)): bit length of m-1, forced to 0 for m<=1.
module modred_bitlen #(
    parameter int unsigned WIDTH = modred_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] bl_c
);

    logic [WIDTH-1:0] m_dec;

    always_comb begin
        m_dec = m - WIDTH'(1);
        bl_c  = '0;
        if (m != '0) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (m_dec[i]) bl_c = WIDTH'(i + 1);
            end
        end
    end

endmodule

// File: rtl/modred_dispatcher.sv
// Initiator for the serial modular reducer: operand stream in, tagged result stream out,
// one job in flight, with a bounded wait on the reducer.
module modred_dispatcher
    import modred_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_load_i,
    input  logic [WIDTH-1:0]     cfg_m_i,
    output logic                 cfg_ok_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_x_i,
    modred_dispatcher_if.master  red,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     out_result_o,
    output logic [WIDTH-1:0]     out_x_o,
    output logic                 out_err_o,
    output logic                 busy_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e           state_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] m_bl_q;
    logic             cfg_ok_q;
    logic             cfg_pend_q;
    logic [WIDTH-1:0] x_q;
    logic             start_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic [WIDTH-1:0] out_x_q;
    logic             out_err_q;
    logic [WIDTH-1:0] bl_c;
    logic             accept_c;

    modred_bitlen #(.WIDTH(WIDTH)) u_bitlen (
        .m    (m_q),
        .bl_c (bl_c)
    );

    assign in_ready_o = (state_q == IDLE) && cfg_ok_q && !cfg_load_i;
    assign accept_c   = in_valid_i && in_ready_o;

    // Job FSM; the modulus and its bit length are only written while IDLE, so the
    // reducer sees a stable x/m/m_bl for the whole job.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            m_q          <= '0;
            m_bl_q       <= '0;
            cfg_ok_q     <= 1'b0;
            cfg_pend_q   <= 1'b0;
            x_q          <= '0;
            start_q      <= 1'b0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_x_q      <= '0;
            out_err_q    <= 1'b0;
        end else begin
            cfg_pend_q <= 1'b0;
            if (cfg_pend_q) begin
                m_bl_q   <= bl_c;
                cfg_ok_q <= (m_q != '0);
            end
            case (state_q)
                IDLE: begin
                    if (cfg_load_i) begin
                        m_q        <= cfg_m_i;
                        cfg_ok_q   <= 1'b0;
                        cfg_pend_q <= 1'b1;
                    end else if (accept_c) begin
                        x_q <= in_x_i;
                        if (in_x_i == '0) begin
                            out_valid_q  <= 1'b1;
                            out_result_q <= '0;
                            out_x_q      <= '0;
                            out_err_q    <= 1'b0;
                            state_q      <= OUT;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (red.valid) begin
                        out_valid_q  <= 1'b1;
                        out_result_q <= red.result;
                        out_x_q      <= x_q;
                        out_err_q    <= 1'b0;
                        state_q      <= OUT;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        out_valid_q  <= 1'b1;
                        out_result_q <= '0;
                        out_x_q      <= x_q;
                        out_err_q    <= 1'b1;
                        state_q      <= OUT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign red.start    = start_q;
    assign red.x        = x_q;
    assign red.m        = m_q;
    assign red.m_bl     = m_bl_q;
    assign cfg_ok_o     = cfg_ok_q;
    assign out_valid_o  = out_valid_q;
    assign out_result_o = out_result_q;
    assign out_x_o      = out_x_q;
    assign out_err_o    = out_err_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_modred_dispatcher.sv
// Bench for modred_dispatcher: behavioural reducer stub with programmable latency,
// x % m and ceil(log2(m)) reference computed with plain arithmetic.
module tb_modred_dispatcher;

    localparam int unsigned W        = 64;
    localparam int unsigned TO_SHORT = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_load;
    logic [W-1:0] cfg_m;
    logic         in_valid, in_valid_to;
    logic [W-1:0] in_x;
    logic         out_ready, out_ready_to;

    logic         cfg_ok, in_ready, out_valid, out_err, busy;
    logic [W-1:0] out_result, out_x;
    logic         cfg_ok_to, in_ready_to, out_valid_to, out_err_to, busy_to;
    logic [W-1:0] out_result_to, out_x_to;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int n_starts = 0;
    int stub_lat = 0;
    int stub_cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    modred_dispatcher_if #(.WIDTH(W)) red ();
    modred_dispatcher_if #(.WIDTH(W)) red_to ();

    modred_dispatcher #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_load_i(cfg_load), .cfg_m_i(cfg_m), .cfg_ok_o(cfg_ok),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_x_i(in_x), .red(red),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_result_o(out_result),
        .out_x_o(out_x), .out_err_o(out_err), .busy_o(busy)
    );

    modred_dispatcher #(.WIDTH(W), .TIMEOUT_CYC(TO_SHORT)) dut_to (
        .clk_i(clk), .rst_ni(rst_n), .cfg_load_i(cfg_load), .cfg_m_i(cfg_m), .cfg_ok_o(cfg_ok_to),
        .in_valid_i(in_valid_to), .in_ready_o(in_ready_to), .in_x_i(in_x), .red(red_to),
        .out_valid_o(out_valid_to), .out_ready_i(out_ready_to), .out_result_o(out_result_to),
        .out_x_o(out_x_to), .out_err_o(out_err_to), .busy_o(busy_to)
    );

    // The second reducer never answers.
    assign red_to.valid  = 1'b0;
    assign red_to.result = '0;

    // Reducer stub: valid pulses stub_lat cycles after the start cycle; 0 = never.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red.valid  <= 1'b0;
            red.result <= '0;
            stub_cnt   <= 0;
        end else begin
            red.valid <= 1'b0;
            if (red.start) begin
                if (stub_lat == 1) begin
                    red.valid  <= 1'b1;
                    red.result <= red.x % red.m;
                end
                stub_cnt <= (stub_lat > 1) ? stub_lat - 1 : 0;
            end else if (stub_cnt > 0) begin
                if (stub_cnt == 1) begin
                    red.valid  <= 1'b1;
                    red.result <= red.x % red.m;
                end
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    always @(posedge clk) if (red.start) n_starts <= n_starts + 1;

    function automatic logic [W-1:0] ref_bl(input logic [W-1:0] m);
        logic [W:0] p;
        int b;
        p = 1;
        b = 0;
        while (p < {1'b0, m}) begin
            p = p << 1;
            b++;
        end
        return W'(b);
    endfunction

    task automatic load_cfg(input logic [W-1:0] m);
        cfg_load = 1'b1;
        cfg_m    = m;
        @(negedge clk);
        cfg_load = 1'b0;
        @(negedge clk);
    endtask

    // Offer x at a negedge while the main DUT is IDLE, then wait for out_valid.
    task automatic run_job(input logic [W-1:0] x, input int lat,
                           output bit got, output int lat_obs, output int starts,
                           output logic [W-1:0] res, output logic [W-1:0] tag, output logic err);
        int t0, s0;
        stub_lat = lat;
        s0 = n_starts;
        in_valid = 1'b1;
        in_x     = x;
        t0       = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && (cyc - t0) < lat + 200) @(negedge clk);
        got     = out_valid;
        lat_obs = cyc - t0;
        starts  = n_starts - s0;
        res     = out_result;
        tag     = out_x;
        err     = out_err;
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_handshake: out_valid=%b busy=%b, required 0 0", name, out_valid, busy);
        else n_pass++;
    endtask

    task automatic check_job(input string name, input logic [W-1:0] x, input logic [W-1:0] m,
                             input int lat, input bit got, input int lat_obs, input int starts,
                             input logic [W-1:0] res, input logic [W-1:0] tag, input logic err);
        logic [W-1:0] exp_res;
        int exp_lat, exp_starts;
        exp_res    = x % m;
        exp_lat    = (x == '0) ? 1 : lat + 2;
        exp_starts = (x == '0) ? 0 : 1;
        n_total++;
        if (!got) $display("FAIL %s_timeout: no out_valid after %0d cycles", name, lat_obs);
        else n_pass++;
        n_total++;
        if (res !== exp_res || tag !== x || err !== 1'b0)
            $display("FAIL %s_data: result=%h tag=%h err=%b, required %h %h 0", name, res, tag, err, exp_res, x);
        else n_pass++;
        n_total++;
        if (lat_obs !== exp_lat || starts !== exp_starts)
            $display("FAIL %s_timing: latency=%0d starts=%0d, required %0d %0d", name, lat_obs, starts, exp_lat, exp_starts);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({cfg_ok, in_ready, out_valid, out_err, busy, red.start} !== 6'b0 ||
            red.m_bl !== '0 || red.m !== '0 || out_result !== '0 || out_x !== '0)
            $display("FAIL reset_outputs: ok=%b rdy=%b vld=%b err=%b busy=%b start=%b mbl=%h m=%h, required all 0",
                     cfg_ok, in_ready, out_valid, out_err, busy, red.start, red.m_bl, red.m);
        else n_pass++;
        n_total++;
        if ({cfg_ok_to, in_ready_to, out_valid_to, busy_to} !== 4'b0)
            $display("FAIL reset_outputs_to: got %b, required 0000", {cfg_ok_to, in_ready_to, out_valid_to, busy_to});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bitlen();
        logic [W-1:0] tm [7] = '{64'hD01, 64'h800, 64'h7FE001, 64'h1, 64'h2, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF};
        int           tb_ [7] = '{12, 11, 23, 0, 1, 2, 64};
        logic [W-1:0] m, r;
        for (int i = 0; i < 7; i++) begin
            load_cfg(tm[i]);
            n_total++;
            if (red.m_bl !== W'(tb_[i]) || red.m !== tm[i] || cfg_ok !== 1'b1)
                $display("FAIL bitlen_%0d: m_bl=%0d m=%h ok=%b, required %0d %h 1", i, red.m_bl, red.m, cfg_ok, tb_[i], tm[i]);
            else n_pass++;
        end
        for (int i = 0; i < 6; i++) begin
            r = {$urandom, $urandom};
            m = r >> $urandom_range(0, 63);
            if (m == '0) m = 64'd5;
            load_cfg(m);
            n_total++;
            if (red.m_bl !== ref_bl(m) || cfg_ok !== 1'b1)
                $display("FAIL bitlen_rand: m=%h m_bl=%0d ok=%b, required %0d 1", m, red.m_bl, cfg_ok, ref_bl(m));
            else n_pass++;
        end
        cfg_load = 1'b1;
        cfg_m    = 64'hD01;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL ready_during_load: in_ready=%b, required 0", in_ready);
        else n_pass++;
        @(negedge clk);
        cfg_load = 1'b0;
        @(negedge clk);
        load_cfg('0);
        in_valid = 1'b1;
        in_x     = 64'h1234;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (cfg_ok !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0)
                $display("FAIL zero_modulus: ok=%b rdy=%b busy=%b, required 0 0 0", cfg_ok, in_ready, busy);
            else n_pass++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        bit got; int lo, st; logic [W-1:0] res, tag; logic err;
        load_cfg(64'hD01);
        run_job(64'h1234, 70, got, lo, st, res, tag, err);
        n_total++;
        if (res !== 64'h533) $display("FAIL basic_result: result=%h, required 533", res);
        else n_pass++;
        check_job("basic", 64'h1234, 64'hD01, 70, got, lo, st, res, tag, err);
        handshake("basic");
    endtask

    task automatic test_bypass();
        bit got; int lo, st; logic [W-1:0] res, tag; logic err;
        run_job('0, 5, got, lo, st, res, tag, err);
        check_job("bypass", '0, 64'hD01, 5, got, lo, st, res, tag, err);
        handshake("bypass");
    endtask

    task automatic test_random();
        bit got; int lo, st, lat; logic [W-1:0] res, tag, x, m, r; logic err;
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) begin
                r = {$urandom, $urandom};
                m = r >> $urandom_range(0, 63);
                if (m == '0) m = 64'd1;
                load_cfg(m);
            end
            x   = {$urandom, $urandom} >> $urandom_range(0, 40);
            lat = $urandom_range(1, 40);
            run_job(x, lat, got, lo, st, res, tag, err);
            check_job("random", x, m, lat, got, lo, st, res, tag, err);
            handshake("random");
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        int t0, waits;
        load_cfg(64'hD01);
        in_valid_to = 1'b1;
        in_x        = 64'h55;
        t0          = cyc;
        waits       = 0;
        @(negedge clk);
        in_valid_to = 1'b0;
        while (!out_valid_to && (cyc - t0) < 300) begin
            if (busy_to && !red_to.start) waits++;
            @(negedge clk);
        end
        n_total++;
        if (out_valid_to !== 1'b1 || out_err_to !== 1'b1 || out_result_to !== '0 || out_x_to !== 64'h55)
            $display("FAIL timeout_out: vld=%b err=%b result=%h tag=%h, required 1 1 0 55",
                     out_valid_to, out_err_to, out_result_to, out_x_to);
        else n_pass++;
        n_total++;
        if (cyc - t0 !== int'(TO_SHORT) + 2 || waits !== int'(TO_SHORT))
            $display("FAIL timeout_cycles: latency=%0d wait=%0d, required %0d %0d", cyc - t0, waits, TO_SHORT + 2, TO_SHORT);
        else n_pass++;
        out_ready_to = 1'b1;
        @(negedge clk);
        out_ready_to = 1'b0;
        n_total++;
        if (busy_to !== 1'b0 || out_valid_to !== 1'b0 || in_ready_to !== 1'b1)
            $display("FAIL timeout_idle: busy=%b vld=%b rdy=%b, required 0 0 1", busy_to, out_valid_to, in_ready_to);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit got; int lo, st, t0; logic [W-1:0] res, tag, m, x1, x2; logic err;
        m  = 64'hF00D_1234_5;
        x1 = {$urandom, $urandom};
        x2 = {$urandom, $urandom} | 64'h1;
        load_cfg(m);
        run_job(x1, 3, got, lo, st, res, tag, err);
        check_job("stall_first", x1, m, 3, got, lo, st, res, tag, err);
        in_valid = 1'b1;
        in_x     = x2;
        for (int i = 0; i < 5; i++) begin
            cfg_load = (i == 2);
            cfg_m    = 64'h777;
            n_total++;
            if (out_valid !== 1'b1 || out_result !== x1 % m || out_x !== x1 || in_ready !== 1'b0)
                $display("FAIL stall_hold: vld=%b result=%h tag=%h rdy=%b, required 1 %h %h 0",
                         out_valid, out_result, out_x, in_ready, x1 % m, x1);
            else n_pass++;
            @(negedge clk);
        end
        cfg_load = 1'b0;
        n_total++;
        if (red.m !== m || red.m_bl !== ref_bl(m))
            $display("FAIL cfg_ignored_busy: m=%h m_bl=%0d, required %h %0d", red.m, red.m_bl, m, ref_bl(m));
        else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL post_handshake: vld=%b rdy=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
        else n_pass++;
        stub_lat = 4;
        t0 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && (cyc - t0) < 200) @(negedge clk);
        check_job("stall_second", x2, m, 4, out_valid, cyc - t0, 1, out_result, out_x, out_err);
        handshake("stall_second");
    endtask

    task automatic test_reset_mid();
        bit got; int lo, st; logic [W-1:0] res, tag; logic err;
        load_cfg(64'h9999);
        stub_lat = 0;
        in_valid = 1'b1;
        in_x     = 64'hABCDE;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL midjob_busy: busy=%b, required 1", busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, out_valid, red.start, cfg_ok, in_ready, out_err} !== 6'b0 || red.m !== '0 ||
            red.x !== '0 || red.m_bl !== '0 || out_result !== '0)
            $display("FAIL midjob_reset: busy=%b vld=%b start=%b ok=%b rdy=%b m=%h x=%h, required all 0",
                     busy, out_valid, red.start, cfg_ok, in_ready, red.m, red.x);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_cfg(64'h9999);
        run_job(64'hABCDE, 5, got, lo, st, res, tag, err);
        check_job("after_reset", 64'hABCDE, 64'h9999, 5, got, lo, st, res, tag, err);
        handshake("after_reset");
    endtask

    initial begin
        cfg_load = 1'b0; cfg_m = '0; in_valid = 1'b0; in_valid_to = 1'b0; in_x = '0;
        out_ready = 1'b0; out_ready_to = 1'b0;
        test_reset();
        test_bitlen();
        test_basic();
        test_bypass();
        test_random();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
